vga_timing_gen: RTL and testbench

//  Raster timing generator that feeds the pixel renderers (DrawX/DrawY/blank consumers) and the
//  VGA/HDMI output stage. Walks an H_TOTAL x V_TOTAL raster one pixel per pix_en strobe.

---
 rtl/vga_timing_gen_if.sv | 25 ++
 rtl/vga_timing_gen.sv | 112 +++++++++++
 tb/tb_vga_timing_gen.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: pixel strobe in, coordinates, flags and delayed sync out.
interface vga_timing_gen_if;
  logic       pix_en;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;
  logic       hs;
  logic       vs;
  logic       de;

  // Timing generator side.
  modport master (
    input  pix_en,
    output DrawX, DrawY, blank, line_start, frame_start, frame_count, hs, vs, de
  );

  // Renderer / output-stage side.
  modport slave (
    output pix_en,
    input  DrawX, DrawY, blank, line_start, frame_start, frame_count, hs, vs, de
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: walks an H_TOTAL x V_TOTAL raster one pixel per
// pix_en strobe, producing coordinates/flags for the renderers and sync/de
// delayed by PIPE_DELAY strobes to match the colour pipeline.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  vga_timing_gen_if.master bus
);

  localparam int unsigned CW      = 10;
  localparam int unsigned FCW     = 8;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] Y_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          SYNC_ON  = SYNC_POL;
  localparam logic          SYNC_OFF = ~SYNC_POL;

  // Coordinates are 10 bits wide, so larger rasters cannot be represented.
  if (H_TOTAL > 1024) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end

  logic [CW-1:0]     x_q, y_q;
  logic              blank_q, line_start_q, frame_start_q;
  logic [FCW-1:0]    frame_count_q;
  logic [PIPE_DELAY:0] hs_pipe, vs_pipe, de_pipe;

  logic [CW-1:0] next_x, next_y;
  logic          next_blank, next_line_start, next_frame_start;
  logic          hs_raw, vs_raw;

  // Next raster position and the flags/raw sync that belong to it.
  always_comb begin
    next_x           = CW'(x_q + CW'(1));
    next_y           = y_q;
    if (x_q == X_LAST) begin
      next_x = '0;
      next_y = (y_q == Y_LAST) ? '0 : CW'(y_q + CW'(1));
    end
    next_blank       = (next_x < X_ACT) && (next_y < Y_ACT);
    next_line_start  = (next_x == '0);
    next_frame_start = (next_x == '0) && (next_y == '0);
    hs_raw = ((next_x >= HS_FIRST) && (next_x <= HS_LAST)) ? SYNC_ON : SYNC_OFF;
    vs_raw = ((next_y >= VS_FIRST) && (next_y <= VS_LAST)) ? SYNC_ON : SYNC_OFF;
  end

  // Raster state; everything, including the sync/de delay line, holds without a strobe.
  // Stage 0 of each delay line is aligned with the coordinates, later stages lag by one strobe each.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= X_LAST;
      y_q           <= Y_LAST;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      hs_pipe       <= {(PIPE_DELAY + 1){SYNC_OFF}};
      vs_pipe       <= {(PIPE_DELAY + 1){SYNC_OFF}};
      de_pipe       <= '0;
    end else if (bus.pix_en) begin
      x_q           <= next_x;
      y_q           <= next_y;
      blank_q       <= next_blank;
      line_start_q  <= next_line_start;
      frame_start_q <= next_frame_start;
      if (next_frame_start) begin
        frame_count_q <= FCW'(frame_count_q + FCW'(1));
      end
      hs_pipe[0] <= hs_raw;
      vs_pipe[0] <= vs_raw;
      de_pipe[0] <= next_blank;
      for (int i = 1; i <= int'(PIPE_DELAY); i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
        de_pipe[i] <= de_pipe[i-1];
      end
    end
  end

  assign bus.DrawX       = x_q;
  assign bus.DrawY       = y_q;
  assign bus.blank       = blank_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_count = frame_count_q;
  assign bus.hs          = hs_pipe[PIPE_DELAY];
  assign bus.vs          = vs_pipe[PIPE_DELAY];
  assign bus.de          = de_pipe[PIPE_DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 800x525 raster (PIPE_DELAY=2) and a
// 7x5 raster (PIPE_DELAY=0) checked every sample against expected vectors.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks   = 0;
  int   failures = 0;
  int   n_a = 0;
  int   n_b = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if bus_a ();
  vga_timing_gen_if bus_b ();

  vga_timing_gen u_dut_a (
    .vga_clk (clk),
    .reset_n (rst_a),
    .bus     (bus_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .PIPE_DELAY(0)
  ) u_dut_b (
    .vga_clk (clk),
    .reset_n (rst_b),
    .bus     (bus_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Packed view: {DrawX, DrawY, blank, line_start, frame_start, hs, vs, de, frame_count}.
  function automatic logic [33:0] obs_a();
    return {bus_a.DrawX, bus_a.DrawY, bus_a.blank, bus_a.line_start, bus_a.frame_start,
            bus_a.hs, bus_a.vs, bus_a.de, bus_a.frame_count};
  endfunction

  function automatic logic [33:0] obs_b();
    return {bus_b.DrawX, bus_b.DrawY, bus_b.blank, bus_b.line_start, bus_b.frame_start,
            bus_b.hs, bus_b.vs, bus_b.de, bus_b.frame_count};
  endfunction

  // Expected default-raster outputs after n strobes since reset.
  function automatic logic [33:0] exp_a(input int n);
    int p, x, y, q, xq, yq;
    logic b, ls, fs, h, v, d;
    logic [7:0] fc;
    if (n == 0) return {10'd799, 10'd524, 6'b000110, 8'd0};
    p  = n - 1;
    x  = p % 800;
    y  = (p / 800) % 525;
    b  = (x < 640) && (y < 480);
    ls = (x == 0);
    fs = ls && (y == 0);
    fc = 8'((p / 420000 + 1) % 256);
    q  = p - 2;
    if (q < 0) begin
      h = 1'b1; v = 1'b1; d = 1'b0;
    end else begin
      xq = q % 800;
      yq = (q / 800) % 525;
      h  = !((xq >= 656) && (xq <= 751));
      v  = !((yq >= 490) && (yq <= 491));
      d  = (xq < 640) && (yq < 480);
    end
    return {10'(x), 10'(y), b, ls, fs, h, v, d, fc};
  endfunction

  // Expected small-raster outputs (7x5, no delay) after n strobes since reset.
  function automatic logic [33:0] exp_b(input int n);
    int p, x, y;
    logic b, ls, fs;
    logic [7:0] fc;
    if (n == 0) return {10'd6, 10'd4, 6'b000110, 8'd0};
    p  = n - 1;
    x  = p % 7;
    y  = (p / 7) % 5;
    b  = (x < 4) && (y < 2);
    ls = (x == 0);
    fs = ls && (y == 0);
    fc = 8'((p / 35 + 1) % 256);
    return {10'(x), 10'(y), b, ls, fs, (x != 5), (y != 3), b, fc};
  endfunction

  task automatic tick_a(input logic en, input string tag);
    bus_a.pix_en = en;
    @(posedge clk);
    if (en && rst_a) n_a++;
    @(negedge clk);
    check(tag, 64'(obs_a()), 64'(exp_a(n_a)));
  endtask

  task automatic tick_b(input logic en, input string tag);
    bus_b.pix_en = en;
    @(posedge clk);
    if (en && rst_b) n_b++;
    @(negedge clk);
    check(tag, 64'(obs_b()), 64'(exp_b(n_b)));
  endtask

  initial begin
    int hs_low, ls_clk, guard;
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.pix_en = 1'b0;
    bus_b.pix_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_a", 64'(obs_a()), 64'(exp_a(0)));
    check("reset_b", 64'(obs_b()), 64'(exp_b(0)));

    // First strobe after release lands on (0,0).
    rst_a = 1'b1;
    tick_a(1'b1, "first_a");
    check("first_xy", 64'({bus_a.DrawX, bus_a.DrawY}), 64'd0);
    check("first_fc", 64'(bus_a.frame_count), 64'd1);
    check("first_flags", 64'({bus_a.blank, bus_a.line_start, bus_a.frame_start}), 64'b111);

    // Continuous strobes over two lines plus a bit.
    for (int i = 0; i < 1700; i++) tick_a(1'b1, "line_a");

    // Alternating strobe: one line spans 1600 clocks.
    hs_low = 0;
    ls_clk = 0;
    for (int i = 0; i < 1600; i++) begin
      tick_a((i % 2) == 0, "alt_a");
      if (bus_a.hs == 1'b0) hs_low++;
      if (bus_a.line_start) ls_clk++;
    end
    check("alt_hs_low_clocks", 64'(hs_low), 64'd192);
    check("alt_ls_clocks", 64'(ls_clk), 64'd2);

    // Mid-line asynchronous reset at DrawX=300.
    guard = 0;
    while (bus_a.DrawX != 10'd300 && guard < 1000) begin
      tick_a(1'b1, "seek_a");
      guard++;
    end
    check("seek_a_found", 64'(bus_a.DrawX), 64'd300);
    bus_a.pix_en = 1'b0;
    #1;
    rst_a = 1'b0;
    n_a = 0;
    #1;
    check("midrst_a", 64'(obs_a()), 64'(exp_a(0)));
    @(negedge clk);
    rst_a = 1'b1;
    tick_a(1'b1, "restart_a");

    // Small raster: run past 256 frames so frame_count wraps.
    rst_b = 1'b1;
    for (int i = 0; i < 256 * 35 + 10; i++) tick_b(1'b1, "small_b");
    check("wrap_fc_b", 64'(bus_b.frame_count), 64'd1);

    // Reset while vs is asserted; vs must deassert at once.
    guard = 0;
    while (bus_b.vs != 1'b0 && guard < 40) begin
      tick_b(1'b1, "seek_b");
      guard++;
    end
    check("seek_b_vs_low", 64'(bus_b.vs), 64'd0);
    bus_b.pix_en = 1'b0;
    #1;
    rst_b = 1'b0;
    n_b = 0;
    #1;
    check("midrst_b", 64'(obs_b()), 64'(exp_b(0)));
    check("midrst_b_vs", 64'(bus_b.vs), 64'd1);
    @(negedge clk);
    rst_b = 1'b1;
    tick_b(1'b1, "restart_b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
